// File: rtl/n2_btb.sv
// rtl/n2_btb.sv - direct-mapped branch target buffer with 2-bit counters and clear sweep
module n2_btb #(
  parameter int ENTRIES = 16,
  parameter int TGT_W   = 16,
  parameter int TAG_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_v_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             ctl_jump_o,
  output logic [31:0]      ctl_tgt_o,
  output logic [31:0]      ctl_pc_o,
  input  logic             upd_v_i,
  input  logic             upd_valid_i,
  input  logic             upd_is_jalr_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [TGT_W-1:0] upd_tgt_i,
  input  logic             flush_i,
  output logic             ready_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_ready;
  logic             w_clear;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [TGT_W-1:0] r_tgt   [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];
  logic             r_jalr  [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_upd_en;
  logic             w_unused_upd_pc;

  assign w_lk_idx = lookup_pc_i[IDX_W+1:2];
  assign w_lk_tag = lookup_pc_i[TAG_LO+TAG_W-1:TAG_LO];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_idx = upd_pc_i[IDX_W+1:2];
  assign w_up_tag = upd_pc_i[TAG_LO+TAG_W-1:TAG_LO];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  // A flush in the same cycle beats any update.
  assign w_upd_en = w_ready && upd_v_i && !flush_i;
  assign w_unused_upd_pc = ^{upd_pc_i[31:TAG_LO+TAG_W], upd_pc_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_INIT: begin
        if (flush_i) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        if (flush_i) begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_ready = (r_state == S_RUN);
    w_clear = (r_state == S_INIT);
  end

  assign ready_o = w_ready;

  // Entry storage carries no reset; the clear sweep initialises it before RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clear) begin
        r_valid[r_idx] <= 1'b0;
        r_ctr[r_idx]   <= 2'b01;
        r_jalr[r_idx]  <= 1'b0;
      end else if (w_upd_en) begin
        if (upd_valid_i) begin
          if (w_up_hit) begin
            if (r_ctr[w_up_idx] != 2'b11) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
          end else begin
            r_valid[w_up_idx] <= 1'b1;
            r_tag[w_up_idx]   <= w_up_tag;
            r_ctr[w_up_idx]   <= 2'b10;
          end
          r_tgt[w_up_idx]  <= upd_tgt_i;
          r_jalr[w_up_idx] <= upd_is_jalr_i;
        end else if (w_up_hit && r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_jump_o <= 1'b0;
      ctl_tgt_o  <= '0;
      ctl_pc_o   <= '0;
    end else if (w_ready && lookup_v_i) begin
      ctl_jump_o <= w_lk_hit && (r_jalr[w_lk_idx] || r_ctr[w_lk_idx][1]);
      ctl_tgt_o  <= 32'(r_tgt[w_lk_idx]);
      ctl_pc_o   <= lookup_pc_i;
    end else begin
      ctl_jump_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n2_btb.sv
// tb/tb_n2_btb.sv - vector table, corner sequences and random run against a reference model
module tb_n2_btb;
  localparam int ENTRIES = 16;
  localparam int TGT_W   = 16;
  localparam int TAG_W   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             lookup_v_i;
  logic [31:0]      lookup_pc_i;
  logic             ctl_jump_o;
  logic [31:0]      ctl_tgt_o;
  logic [31:0]      ctl_pc_o;
  logic             upd_v_i;
  logic             upd_valid_i;
  logic             upd_is_jalr_i;
  logic [31:0]      upd_pc_i;
  logic [TGT_W-1:0] upd_tgt_i;
  logic             flush_i;
  logic             ready_o;

  always #5 clk = ~clk;

  n2_btb #(.ENTRIES(ENTRIES), .TGT_W(TGT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_v_i(lookup_v_i), .lookup_pc_i(lookup_pc_i),
    .ctl_jump_o(ctl_jump_o), .ctl_tgt_o(ctl_tgt_o), .ctl_pc_o(ctl_pc_o),
    .upd_v_i(upd_v_i), .upd_valid_i(upd_valid_i), .upd_is_jalr_i(upd_is_jalr_i),
    .upd_pc_i(upd_pc_i), .upd_tgt_i(upd_tgt_i),
    .flush_i(flush_i), .ready_o(ready_o)
  );

  typedef struct {
    bit          rst;
    bit          flush;
    bit          lk_v;
    logic [31:0] lk_pc;
    bit          up_v;
    bit          up_t;
    bit          up_j;
    logic [31:0] up_pc;
    logic [15:0] up_tgt;
    bit          chk;
    bit          e_jump;
    logic [31:0] e_tgt;
    logic [31:0] e_pc;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: entries as plain integers, init modelled as a countdown.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_jalr  [ENTRIES];
  int          m_busy = ENTRIES;
  bit          e_jump;
  logic [31:0] e_tgt;
  logic [31:0] e_pc;

  function automatic int unsigned idx_of(logic [31:0] pc);
    int unsigned p = pc;
    return (p / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    int unsigned p = pc;
    return (p / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t upd(logic [31:0] pc, logic [15:0] tgt, bit taken, bit jalr);
    vec_t v = idle();
    v.up_v = 1'b1; v.up_pc = pc; v.up_tgt = tgt; v.up_t = taken; v.up_j = jalr;
    return v;
  endfunction

  function automatic vec_t lk(logic [31:0] pc, bit ej, logic [31:0] et);
    vec_t v = idle();
    v.lk_v = 1'b1; v.lk_pc = pc; v.chk = 1'b1; v.e_jump = ej; v.e_tgt = et; v.e_pc = pc;
    return v;
  endfunction

  task automatic cycle(input vec_t v);
    int unsigned li, lt, ui, ut;
    bit uhit;
    rst = v.rst; flush_i = v.flush;
    lookup_v_i = v.lk_v; lookup_pc_i = v.lk_pc;
    upd_v_i = v.up_v; upd_valid_i = v.up_t; upd_is_jalr_i = v.up_j;
    upd_pc_i = v.up_pc; upd_tgt_i = v.up_tgt;
    li = idx_of(v.lk_pc); lt = tag_of(v.lk_pc);
    if (v.rst) begin
      e_jump = 1'b0; e_tgt = '0; e_pc = '0;
    end else if (m_busy == 0 && v.lk_v) begin
      e_jump = m_valid[li] && m_tag[li] == lt && (m_jalr[li] || m_ctr[li] >= 2);
      e_tgt = m_tgt[li]; e_pc = v.lk_pc;
    end else begin
      e_jump = 1'b0;
    end
    if (v.rst || v.flush) begin
      m_busy = ENTRIES;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_ctr[i] = 1; m_jalr[i] = 1'b0;
      end
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (v.up_v) begin
      ui = idx_of(v.up_pc); ut = tag_of(v.up_pc);
      uhit = m_valid[ui] && m_tag[ui] == ut;
      if (v.up_t) begin
        m_ctr[ui] = uhit ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3) : 2;
        m_valid[ui] = 1'b1; m_tag[ui] = ut;
        m_tgt[ui] = {16'h0, v.up_tgt}; m_jalr[ui] = v.up_j;
      end else if (uhit) begin
        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    check("model_jump", ctl_jump_o, e_jump);
    check("model_tgt", ctl_tgt_o, e_tgt);
    check("model_pc", ctl_pc_o, e_pc);
    check("model_ready", ready_o, m_busy == 0);
    if (v.chk) begin
      check("tbl_jump", ctl_jump_o, v.e_jump);
      check("tbl_tgt", ctl_tgt_o, v.e_tgt);
      check("tbl_pc", ctl_pc_o, v.e_pc);
    end
  endtask

  task automatic expect_sweep(string name);
    for (int i = 0; i < ENTRIES; i++) begin
      cycle(idle());
      check(name, ready_o, (i == ENTRIES - 1));
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1; m_jalr[i] = 1'b0;
    end

    tbl.push_back(upd(32'h100, 16'h0180, 1, 0));
    tbl.push_back(lk(32'h100, 1, 32'h180));
    tbl.push_back(upd(32'h100, 16'h0, 0, 0));
    tbl.push_back(upd(32'h100, 16'h0, 0, 0));
    tbl.push_back(lk(32'h100, 0, 32'h180));
    tbl.push_back(upd(32'h100, 16'h0180, 1, 0));
    tbl.push_back(lk(32'h100, 0, 32'h180));
    tbl.push_back(upd(32'h100, 16'h0180, 1, 0));
    tbl.push_back(lk(32'h100, 1, 32'h180));
    for (int i = 0; i < 3; i++) tbl.push_back(upd(32'h100, 16'h0180, 1, 0));
    tbl.push_back(lk(32'h100, 1, 32'h180));
    tbl.push_back(upd(32'h100, 16'h0, 0, 0));
    tbl.push_back(lk(32'h100, 1, 32'h180));
    tbl.push_back(lk(32'h140, 0, 32'h180));
    tbl.push_back(upd(32'h140, 16'h0200, 1, 0));
    tbl.push_back(lk(32'h140, 1, 32'h200));
    tbl.push_back(lk(32'h100, 0, 32'h200));
    tbl.push_back(upd(32'h80, 16'h0400, 1, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(upd(32'h80, 16'h0, 0, 0));
    tbl.push_back(lk(32'h80, 1, 32'h400));
    v = upd(32'h100, 16'h0180, 1, 0);
    v.lk_v = 1'b1; v.lk_pc = 32'h100; v.chk = 1'b1;
    v.e_jump = 1'b0; v.e_tgt = 32'h400; v.e_pc = 32'h100;
    tbl.push_back(v);
    tbl.push_back(lk(32'h100, 1, 32'h180));

    // Reset, then the init sweep with a lookup held on every cycle.
    v = idle(); v.rst = 1'b1;
    cycle(v);
    cycle(v);
    check("rst_jump", ctl_jump_o, 0);
    check("rst_tgt", ctl_tgt_o, 0);
    check("rst_pc", ctl_pc_o, 0);
    check("rst_ready", ready_o, 0);
    for (int i = 0; i < ENTRIES; i++) begin
      v = idle(); v.lk_v = 1'b1; v.lk_pc = 32'h100;
      cycle(v);
      check("init_jump", ctl_jump_o, 0);
      check("init_ready", ready_o, (i == ENTRIES - 1));
    end

    foreach (tbl[i]) cycle(tbl[i]);

    // Flush colliding with an update: flush wins, old target survives the sweep.
    v = upd(32'h100, 16'h0300, 1, 0); v.flush = 1'b1;
    cycle(v);
    check("flush_ready", ready_o, 0);
    expect_sweep("flush_sweep_ready");
    cycle(lk(32'h100, 0, 32'h180));

    // Flush in the middle of a sweep restarts it from zero.
    v = idle(); v.flush = 1'b1;
    cycle(v);
    for (int i = 0; i < 5; i++) cycle(idle());
    cycle(v);
    expect_sweep("reflush_sweep_ready");

    // Reset mid-sweep restarts it as well.
    cycle(v);
    for (int i = 0; i < 7; i++) cycle(idle());
    v = idle(); v.rst = 1'b1;
    cycle(v);
    expect_sweep("rst_sweep_ready");

    for (int n = 0; n < 2500; n++) begin
      v = idle();
      v.rst   = ($urandom_range(0, 599) == 0);
      v.flush = ($urandom_range(0, 99) == 0);
      v.lk_v  = bit'($urandom_range(0, 3) != 0);
      v.lk_pc = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 3)) << 6)
              | (32'($urandom_range(0, ENTRIES - 1)) << 2);
      v.up_v  = bit'($urandom_range(0, 1));
      v.up_t  = bit'($urandom_range(0, 2) != 0);
      v.up_j  = ($urandom_range(0, 7) == 0);
      v.up_pc = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 3)) << 6)
              | (32'($urandom_range(0, ENTRIES - 1)) << 2);
      v.up_tgt = 16'($urandom);
      cycle(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n2_btb.md
# n2_btb

Branch target buffer for the NanoCore two-issue pipeline. It is the prediction-side counterpart of the execute stage. At fetch it answers a PC lookup with a predicted jump/target, one cycle later, and the execute stage returns that prediction as its control input. It also absorbs the execute stage's BTB update stream: outcome, PC, target and a JALR flag. The block is direct-mapped with per-entry 2-bit saturating counters and a sequential clear FSM.

## Interface
Parameters:
- `ENTRIES`, 16: number of entries; power of two, ≥4.
- `TGT_W`, 16: stored target width; output target is zero-extended to 32.
- `TAG_W`, 10: tag bits, taken from `pc[IDX_W+2+TAG_W-1:IDX_W+2]`, where `IDX_W = log2(ENTRIES)`.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_v_i`  in  1  fetch lookup request.
- `lookup_pc_i`  in  32  fetch PC.
- `ctl_jump_o`  out  1  predicted taken.
- `ctl_tgt_o`  out  32  predicted target, zero-extended.
- `ctl_pc_o`  out  32  PC the prediction belongs to.
- `upd_v_i`  in  1  update strobe from execute.
- `upd_valid_i`  in  1  1 = branch taken / JALR, 0 = not taken.
- `upd_is_jalr_i`  in  1  update is a JALR.
- `upd_pc_i`  in  32  PC of the updating branch.
- `upd_tgt_i`  in  TGT_W  resolved target.
- `flush_i`  in  1  invalidate the whole table.
- `ready_o`  out  1  table initialised; 0 during the clear sweep.

## Operation
- Each entry holds `valid`, `tag[TAG_W]`, `tgt[TGT_W]`, `ctr[2]` and `jalr`. Index = `pc[IDX_W+1:2]`.
- **FSM states:**
  - **INIT:** clear counter `idx` sweeps 0..ENTRIES-1, one entry per cycle, writing `valid=0, ctr=01, jalr=0`. Leave for RUN after writing entry ENTRIES-1. `ready_o=0`.
  - **RUN:** `ready_o=1`. `flush_i` sends the FSM to INIT with `idx=0`.
- **Lookup (RUN, `lookup_v_i=1`):**
  - `hit = valid && tag == lookup tag`.
  - `ctl_jump_o <= hit && (jalr || ctr[1])`.
  - `ctl_tgt_o <= {0, tgt}`, `ctl_pc_o <= lookup_pc_i`.
- **Lookup with `lookup_v_i=0` or in INIT:** `ctl_jump_o <= 0`; `ctl_tgt_o` and `ctl_pc_o` hold.
- **Taken update (RUN, `upd_v_i`, `upd_valid_i=1`):**
  - Hit: `ctr` saturating-increments (11 stays 11); `tgt` and `jalr` are overwritten.
  - Miss: allocate, overwriting any alias, with `valid=1`, new tag, `tgt=upd_tgt_i`, `ctr=10`, `jalr=upd_is_jalr_i`.
- **Not-taken update (`upd_valid_i=0`):**
  - Hit: `ctr` saturating-decrements (00 stays 00); the entry stays valid.
  - Miss: no change.
- JALR entries predict taken on every hit, regardless of `ctr`.
- **Same-cycle lookup and update to the same index:** the lookup sees pre-update contents; there is no bypass.
- **Updates and flushes outside RUN:**
  - Updates arriving in INIT are dropped.
  - `flush_i` asserted in the same cycle as an update: the flush wins and the update is dropped.
  - `flush_i` asserted during INIT restarts the sweep at `idx=0`.
- **`rst` at any time, including mid-sweep:** FSM returns to INIT with `idx=0`.

## Timing
- **Reset values:** `ctl_jump_o=0`, `ctl_tgt_o=0`, `ctl_pc_o=0`, `ready_o=0`, FSM=INIT, `idx=0`.
- **Init latency:** `ready_o` rises exactly ENTRIES cycles after the first cycle with `rst=0` (or after the flush cycle).
- **Lookup latency:** one cycle. A request in cycle N produces outputs valid in cycle N+1.
- **Update visibility:** an update in cycle N changes the array at the edge ending N; a lookup in N+1 reflects it.
- There is no backpressure. One lookup and one update are accepted every cycle.

## Test plan
- **Reset and init sweep:** deassert `rst` with `lookup_v_i=1` and PC 0x100 each cycle -> `ctl_jump_o=0` throughout; `ready_o` rises after 16 cycles.
- **Taken allocate:** taken update PC 0x100, tgt 0x0180, then lookup 0x100 -> next cycle `ctl_jump_o=1`, `ctl_tgt_o=0x00000180`, `ctl_pc_o=0x100`.
- **Counter hysteresis:** starting from the allocated entry (ctr=10):
  - Two not-taken updates -> lookup `jump=0` (ctr 00).
  - One taken update -> `jump=0` (ctr 01).
  - Another taken update -> `jump=1` (ctr 10).
  - Three more taken updates -> still `jump=1` (saturated at 11).
- **Aliasing:** PCs 0x100 and 0x140 share index 0 with different tags.
  - After 0x100 is allocated, lookup 0x140 -> `jump=0`.
  - Taken update 0x140 tgt 0x0200 -> lookup 0x140 hits with 0x200; lookup 0x100 now misses.
- **JALR entry:** taken update with `upd_is_jalr_i=1`, PC 0x80, tgt 0x0400, then three not-taken updates -> lookup 0x80 still gives `jump=1`, `tgt=0x400`.
- **Flush collision and bypass:**
  - `flush_i` asserted together with a taken update PC 0x100 -> `ready_o=0` for 16 cycles; afterwards lookup 0x100 -> `jump=0`.
  - With the table in RUN, a lookup and a taken allocate to PC 0x100 in the same cycle -> that lookup returns `jump=0`; a lookup in the next cycle returns `jump=1`.
